// File: rtl/pvt_monitor_scheduler.sv
// Sweeps a set of delay-chain PVT monitors one at a time: start pulse, settle window, capture.
// Keeps the last result per monitor, running min/max, and a saturating count of finished sweeps.
module pvt_monitor_scheduler #(
  parameter int NUM_MON       = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 256,
  parameter int IDX_W         = $clog2(NUM_MON)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         single_shot,
  input  logic                         clear,
  input  logic [15:0]                  interval,
  output logic [NUM_MON-1:0]           mon_start,
  input  logic [NUM_MON*CNT_WIDTH-1:0] mon_cnt,
  input  logic [IDX_W-1:0]             rd_sel,
  output logic [CNT_WIDTH-1:0]         rd_data,
  output logic                         rd_valid,
  output logic [CNT_WIDTH-1:0]         min_cnt,
  output logic [CNT_WIDTH-1:0]         max_cnt,
  output logic                         busy,
  output logic                         sweep_done,
  output logic [15:0]                  sweep_cnt,
  output logic [2:0]                   dbg_state
);

  localparam int WCW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [15:0]          gap_q, gap_d;
  logic [CNT_WIDTH-1:0] result_q [NUM_MON];
  logic [NUM_MON-1:0]   valid_q, valid_d;
  logic [CNT_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [15:0]          sweep_cnt_q, sweep_cnt_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] sample;
  logic                 last_mon;

  assign sample   = mon_cnt[int'(idx_q)*CNT_WIDTH +: CNT_WIDTH];
  assign last_mon = (idx_q == IDX_W'(NUM_MON - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (enable || single_shot) state_d = S_START;
      end
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WCW'(SETTLE_CYCLES - 1)) state_d = S_CAPTURE;
        else                                   wait_d  = wait_q + 1'b1;
      end
      S_CAPTURE: begin
        if (!last_mon) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_START;
        end else begin
          idx_d = '0;
          if (!enable)              state_d = S_IDLE;
          else if (interval == '0)  state_d = S_START;
          else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // widened compare so a shrinking interval cannot strand the counter
        if (!enable)                                         state_d = S_IDLE;
        else if (({1'b0, gap_q} + 17'd1) >= {1'b0, interval}) state_d = S_START;
        else                                                 gap_d   = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    min_d       = min_q;
    max_d       = max_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    if (state_q == S_CAPTURE) begin
      valid_d[idx_q] = 1'b1;
      if (valid_q == '0) begin
        min_d = sample;
        max_d = sample;
      end else begin
        if (sample < min_q) min_d = sample;
        if (sample > max_q) max_d = sample;
      end
      if (last_mon) begin
        done_d = 1'b1;
        if (sweep_cnt_q != 16'hFFFF) sweep_cnt_d = sweep_cnt_q + 16'd1;
      end
    end
    // clear overrides a coincident capture; result registers are left alone
    if (clear) begin
      valid_d     = '0;
      min_d       = '0;
      max_d       = '0;
      sweep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      gap_q       <= '0;
      valid_q     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sweep_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      valid_q     <= valid_d;
      min_q       <= min_d;
      max_q       <= max_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MON; k++) result_q[k] <= '0;
    end else if (state_q == S_CAPTURE) begin
      result_q[idx_q] <= sample;
    end
  end

  always_comb begin
    mon_start = '0;
    if (state_q == S_START) mon_start[idx_q] = 1'b1;
  end

  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    if (int'(rd_sel) < NUM_MON) begin
      rd_data  = result_q[rd_sel];
      rd_valid = valid_q[rd_sel];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign sweep_done = done_q;
  assign sweep_cnt  = sweep_cnt_q;
  assign min_cnt    = min_q;
  assign max_cnt    = max_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pvt_monitor_scheduler.sv
// Bench for pvt_monitor_scheduler: single shot, continuous, interval 0, clear on capture,
// reset mid-sweep and sweep counter saturation; start pulses are scoreboarded.
module tb_pvt_monitor_scheduler;

  localparam int NM    = 4;
  localparam int CW    = 8;
  localparam int SC    = 16;
  localparam int IW    = 2;
  localparam int SWEEP = NM * (SC + 2);
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              single_shot = 1'b0;
  logic              clear = 1'b0;
  logic [15:0]       interval = '0;
  logic [NM-1:0]     mon_start;
  logic [NM*CW-1:0]  mon_cnt = '0;
  logic [IW-1:0]     rd_sel = '0;
  logic [CW-1:0]     rd_data;
  logic              rd_valid;
  logic [CW-1:0]     min_cnt, max_cnt;
  logic              busy, sweep_done;
  logic [15:0]       sweep_cnt;
  logic [2:0]        dbg_state;

  pvt_monitor_scheduler #(
    .NUM_MON(NM), .CNT_WIDTH(CW), .SETTLE_CYCLES(SC), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .clear(clear), .interval(interval), .mon_start(mon_start), .mon_cnt(mon_cnt),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .min_cnt(min_cnt),
    .max_cnt(max_cnt), .busy(busy), .sweep_done(sweep_done), .sweep_cnt(sweep_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NM-1:0] exp_q[$];
  int start_cyc[$];
  logic [CW-1:0] cnt_v[NM];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every start pulse must match the next expected one-hot value
  always @(negedge clk) begin
    if (rst_n && mon_start != '0) begin
      if (exp_q.size() == 0) check("unexpected_start", 32'(mon_start), 32'd0);
      else                   check("start_onehot", 32'(mon_start), 32'(exp_q.pop_front()));
      start_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    for (int k = 0; k < NM; k++) exp_q.push_back(NM'(1) << k);
  endtask

  task automatic apply_cnts();
    for (int k = 0; k < NM; k++) mon_cnt[k*CW +: CW] = cnt_v[k];
  endtask

  task automatic pulse_single(output int c);
    tick(1);
    single_shot = 1'b1;
    tick(1);
    single_shot = 1'b0;
    c = cyc;
  endtask

  task automatic pulse_clear();
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    logic found;
    found = 1'b0;
    d = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        found = 1'b1;
        d = cyc;
      end
    end
    check("sweep_done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_read(input int k, input logic [CW-1:0] ed, input logic ev);
    rd_sel = IW'(k);
    #1;
    check($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(ed));
    check($sformatf("rd_valid[%0d]", k), 32'(rd_valid), 32'(ev));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mon_start"}, 32'(mon_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    check({tag, "_sweep_cnt"}, 32'(sweep_cnt), 32'd0);
    check({tag, "_min"}, 32'(min_cnt), 32'd0);
    check({tag, "_max"}, 32'(max_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, d1, d2;
    logic [CW-1:0] all_v[2*NM];
    logic [CW-1:0] emin, emax;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    for (int k = 0; k < NM; k++) check_read(k, '0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // single shot 10/20/30/40, with an ignored single_shot mid-sweep
    for (int k = 0; k < NM; k++) cnt_v[k] = CW'(10 * (k + 1));
    apply_cnts();
    start_cyc.delete();
    push_sweep();
    pulse_single(c);
    check("busy_in_start", 32'(busy), 32'd1);
    tick(30);
    single_shot = 1'b1;
    tick(1);
    single_shot = 1'b0;
    wait_done(200, d);
    check("done_latency", 32'(d - c), 32'(SWEEP));
    check("num_starts", 32'(start_cyc.size()), 32'(NM));
    if (start_cyc.size() == NM) begin
      check("first_start_cycle", 32'(start_cyc[0]), 32'(c));
      for (int k = 1; k < NM; k++)
        check($sformatf("start_spacing%0d", k), 32'(start_cyc[k] - start_cyc[k-1]), 32'(SC + 2));
    end
    check("ss_sweep_cnt", 32'(sweep_cnt), 32'd1);
    check("ss_min", 32'(min_cnt), 32'd10);
    check("ss_max", 32'(max_cnt), 32'd40);
    check("ss_idle", 32'(dbg_state), 32'(ST_IDLE));
    for (int k = 0; k < NM; k++) check_read(k, cnt_v[k], 1'b1);
    @(negedge clk);
    check("done_one_cycle", 32'(sweep_done), 32'd0);
    tick(40);
    check("ss_no_extra_sweep", 32'(exp_q.size()), 32'd0);

    // clear on the capture cycle of monitor 2
    start_cyc.delete();
    push_sweep();
    pulse_single(c);
    tick(2 * (SC + 2) + SC + 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    for (int k = 0; k < NM; k++) check_read(k, cnt_v[k], 1'b0);
    check("clr_sweep_cnt", 32'(sweep_cnt), 32'd0);
    check("clr_min", 32'(min_cnt), 32'd0);
    wait_done(200, d);
    check("clr_min_after", 32'(min_cnt), 32'd40);
    check("clr_max_after", 32'(max_cnt), 32'd40);
    check("clr_sweep_cnt_after", 32'(sweep_cnt), 32'd1);
    for (int k = 0; k < NM; k++) check_read(k, cnt_v[k], (k == NM - 1));

    // reset during the settle window of monitor 1
    start_cyc.delete();
    push_sweep();
    pulse_single(c);
    tick(SC + 2 + 7);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    for (int k = 0; k < NM; k++) check_read(k, '0, 1'b0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    start_cyc.delete();
    push_sweep();
    pulse_single(c);
    wait_done(200, d);
    check("post_reset_sweep_cnt", 32'(sweep_cnt), 32'd1);
    check("post_reset_first_start", 32'(start_cyc.size() > 0 ? start_cyc[0] : -1), 32'(c));

    // continuous mode, interval 5, enable dropped mid second sweep
    pulse_clear();
    for (int k = 0; k < NM; k++) begin
      cnt_v[k] = CW'($urandom_range(1, 255));
      all_v[k] = cnt_v[k];
    end
    apply_cnts();
    start_cyc.delete();
    push_sweep();
    push_sweep();
    interval = 16'd5;
    tick(1);
    enable = 1'b1;
    wait_done(200, d1);
    emin = all_v[0];
    emax = all_v[0];
    for (int k = 1; k < NM; k++) begin
      if (all_v[k] < emin) emin = all_v[k];
      if (all_v[k] > emax) emax = all_v[k];
    end
    check("cont_min1", 32'(min_cnt), 32'(emin));
    check("cont_max1", 32'(max_cnt), 32'(emax));
    check("cont_sweep_cnt1", 32'(sweep_cnt), 32'd1);
    for (int k = 0; k < NM; k++) begin
      cnt_v[k] = CW'($urandom_range(1, 255));
      all_v[NM + k] = cnt_v[k];
    end
    apply_cnts();
    tick(30);
    enable = 1'b0;
    wait_done(200, d2);
    for (int k = NM; k < 2 * NM; k++) begin
      if (all_v[k] < emin) emin = all_v[k];
      if (all_v[k] > emax) emax = all_v[k];
    end
    if (start_cyc.size() == 2 * NM) begin
      check("gap_length", 32'(start_cyc[NM] - d1), 32'd5);
      check("sweep2_length", 32'(d2 - start_cyc[NM]), 32'(SWEEP));
    end else begin
      check("cont_num_starts", 32'(start_cyc.size()), 32'(2 * NM));
    end
    check("cont_min2", 32'(min_cnt), 32'(emin));
    check("cont_max2", 32'(max_cnt), 32'(emax));
    check("cont_sweep_cnt2", 32'(sweep_cnt), 32'd2);
    check("cont_idle", 32'(dbg_state), 32'(ST_IDLE));
    for (int k = 0; k < NM; k++) check_read(k, cnt_v[k], 1'b1);
    tick(40);
    check("cont_no_extra_sweep", 32'(exp_q.size()), 32'd0);

    // interval 0: back-to-back sweeps
    interval = 16'd0;
    start_cyc.delete();
    push_sweep();
    push_sweep();
    tick(1);
    enable = 1'b1;
    wait_done(200, d1);
    tick(20);
    enable = 1'b0;
    wait_done(200, d2);
    if (start_cyc.size() == 2 * NM)
      check("zero_gap_start", 32'(start_cyc[NM]), 32'(d1));
    else
      check("zero_gap_num_starts", 32'(start_cyc.size()), 32'(2 * NM));
    check("zero_gap_sweep_cnt", 32'(sweep_cnt), 32'd4);

    // enable dropped during GAP returns to IDLE without another sweep
    interval = 16'd5;
    push_sweep();
    tick(1);
    enable = 1'b1;
    wait_done(200, d);
    enable = 1'b0;
    tick(20);
    check("gap_abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("gap_abort_no_start", 32'(exp_q.size()), 32'd0);
    check("gap_abort_sweep_cnt", 32'(sweep_cnt), 32'd5);

    // sweep counter saturation
    force dut.sweep_cnt_q = 16'hFFFE;
    tick(2);
    release dut.sweep_cnt_q;
    tick(1);
    check("sat_preload", 32'(sweep_cnt), 32'h0000FFFE);
    push_sweep();
    pulse_single(c);
    wait_done(200, d);
    check("sat_reach", 32'(sweep_cnt), 32'h0000FFFF);
    push_sweep();
    pulse_single(c);
    wait_done(200, d);
    check("sat_hold", 32'(sweep_cnt), 32'h0000FFFF);
    tick(5);
    check("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
